// File: rtl/riscv_soft_axi_lite_host_master_if.sv
// rtl/riscv_soft_axi_lite_host_master_if.sv - AXI4-Lite channel bundle between the host master and a slave.
`ifndef AXI_LITE_ADDR_WIDTH
`define AXI_LITE_ADDR_WIDTH 32
`endif
`ifndef AXI_LITE_BUS_WIDTH
`define AXI_LITE_BUS_WIDTH 32
`endif

interface riscv_soft_axi_lite_host_master_if #(
  parameter int ADDR_WIDTH = `AXI_LITE_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_LITE_BUS_WIDTH
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/riscv_soft_axi_lite_host_master.sv
// rtl/riscv_soft_axi_lite_host_master.sv - single-outstanding AXI4-Lite master driven by a host command/response port.
`ifndef AXI_LITE_ADDR_WIDTH
`define AXI_LITE_ADDR_WIDTH 32
`endif
`ifndef AXI_LITE_BUS_WIDTH
`define AXI_LITE_BUS_WIDTH 32
`endif

module riscv_soft_axi_lite_host_master #(
  parameter int ADDR_WIDTH = `AXI_LITE_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_LITE_BUS_WIDTH,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_write,
  output logic [LAT_WIDTH-1:0]    rsp_latency,
  riscv_soft_axi_lite_host_master_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_pend, w_pend;
  logic [LAT_WIDTH-1:0]    lat_cnt, lat_inc;

  logic awvalid, wvalid, bready, arvalid, rready;
  logic accept, b_hs, r_hs, counting;

  assign accept   = cmd_valid && cmd_ready;
  assign b_hs     = bready && axi.M_AXI_BVALID;
  assign r_hs     = rready && axi.M_AXI_RVALID;
  assign counting = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);
  // Count includes the cycle in which the B/R handshake itself happens.
  assign lat_inc  = (&lat_cnt) ? lat_cnt : lat_cnt + LAT_WIDTH'(1);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the host never sees ready while held in reset.
        cmd_ready = M_AXI_ARESETN;
        if (cmd_valid && M_AXI_ARESETN) begin
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        awvalid = aw_pend;
        wvalid  = w_pend;
        if ((!aw_pend || axi.M_AXI_AWREADY) && (!w_pend || axi.M_AXI_WREADY)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (axi.M_AXI_BVALID) state_next = RSP;
      end
      RD_REQ: begin
        arvalid = 1'b1;
        if (axi.M_AXI_ARREADY) state_next = RD_RESP;
      end
      RD_RESP: begin
        rready = 1'b1;
        if (axi.M_AXI_RVALID) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      lat_cnt     <= '0;
      rsp_data    <= '0;
      rsp_resp    <= 2'b00;
      rsp_write   <= 1'b0;
      rsp_latency <= '0;
    end else begin
      if (accept) begin
        aw_pend <= cmd_write;
        w_pend  <= cmd_write;
        lat_cnt <= '0;
      end else if (counting) begin
        lat_cnt <= lat_inc;
      end
      // AW and W retire independently; each VALID drops after its own handshake.
      if (state == WR_REQ) begin
        if (axi.M_AXI_AWREADY) aw_pend <= 1'b0;
        if (axi.M_AXI_WREADY)  w_pend  <= 1'b0;
      end
      if (b_hs) begin
        rsp_data    <= '0;
        rsp_resp    <= axi.M_AXI_BRESP;
        rsp_write   <= 1'b1;
        rsp_latency <= lat_inc;
      end else if (r_hs) begin
        rsp_data    <= axi.M_AXI_RDATA;
        rsp_resp    <= axi.M_AXI_RRESP;
        rsp_write   <= 1'b0;
        rsp_latency <= lat_inc;
      end
    end
  end

  assign axi.M_AXI_AWADDR  = addr_q;
  assign axi.M_AXI_AWVALID = awvalid;
  assign axi.M_AXI_WDATA   = wdata_q;
  assign axi.M_AXI_WSTRB   = wstrb_q;
  assign axi.M_AXI_WVALID  = wvalid;
  assign axi.M_AXI_BREADY  = bready;
  assign axi.M_AXI_ARADDR  = addr_q;
  assign axi.M_AXI_ARVALID = arvalid;
  assign axi.M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_riscv_soft_axi_lite_host_master.sv
// tb/tb_riscv_soft_axi_lite_host_master.sv - self-checking bench for the AXI4-Lite host master.
module tb_riscv_soft_axi_lite_host_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          rsp_write;
  logic [LW-1:0] rsp_latency;

  riscv_soft_axi_lite_host_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  riscv_soft_axi_lite_host_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_latency(rsp_latency),
    .axi(axi)
  );

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    int            aw, w, b, ar, r;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    int            rdy;
    logic [31:0]   exp_data;
    logic [LW-1:0] exp_lat;
    int            exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          wr;
    logic [LW-1:0] lat;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  vec_t vt[7];

  int c_aw, c_w, c_b, c_ar, c_r;
  logic [1:0]  c_resp;
  logic [31:0] c_rdata;
  bit stray = 1'b0;

  int aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_hi, w_hi, ar_hi, stab_err;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_done, w_done, b_pend, r_pend, aw_pv, w_pv, ar_pv;
  logic [31:0] aw_pa, w_pd, ar_pa, got_awaddr, got_wdata, got_araddr;
  logic [3:0]  w_ps, got_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int aw, input int w, input int b,
                              input int ar, input int r, input logic [31:0] rdata,
                              input logic [1:0] resp, input int rdy, input logic [31:0] exp_data,
                              input logic [LW-1:0] exp_lat, input int exp_cyc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.aw = aw; v.w = w; v.b = b; v.ar = ar; v.r = r;
    v.rdata = rdata; v.resp = resp; v.rdy = rdy;
    v.exp_data = exp_data; v.exp_lat = exp_lat; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  // Slave model: READY after a programmed number of VALID cycles, B/R after a programmed stall.
  initial begin
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_BVALID = 1'b0; axi.M_AXI_BRESP = 2'b00;
    axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RDATA = '0;
    stab_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_BVALID = 1'b0; axi.M_AXI_RVALID = 1'b0;
        b_pend = 0; r_pend = 0; aw_done = 0; w_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_pv = 0; w_pv = 0; ar_pv = 0;
      end else begin
        axi.M_AXI_BRESP = c_resp;
        if (b_pend) begin
          axi.M_AXI_BVALID = (b_cnt >= c_b);
          if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin b_hs++; b_pend = 0; end
          else b_cnt++;
        end else axi.M_AXI_BVALID = stray;
        axi.M_AXI_RRESP = c_resp;
        axi.M_AXI_RDATA = c_rdata;
        if (r_pend) begin
          axi.M_AXI_RVALID = (r_cnt >= c_r);
          if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin r_hs++; r_pend = 0; end
          else r_cnt++;
        end else axi.M_AXI_RVALID = stray;
        if (axi.M_AXI_AWVALID) begin
          if (aw_pv && axi.M_AXI_AWADDR != aw_pa) stab_err++;
          aw_hi++;
          axi.M_AXI_AWREADY = (aw_cnt >= c_aw); aw_cnt++;
          if (axi.M_AXI_AWREADY) begin aw_hs++; got_awaddr = axi.M_AXI_AWADDR; aw_done = 1; end
        end else begin axi.M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
        aw_pv = axi.M_AXI_AWVALID; aw_pa = axi.M_AXI_AWADDR;
        if (axi.M_AXI_WVALID) begin
          if (w_pv && (axi.M_AXI_WDATA != w_pd || axi.M_AXI_WSTRB != w_ps)) stab_err++;
          w_hi++;
          axi.M_AXI_WREADY = (w_cnt >= c_w); w_cnt++;
          if (axi.M_AXI_WREADY) begin
            w_hs++; got_wdata = axi.M_AXI_WDATA; got_wstrb = axi.M_AXI_WSTRB; w_done = 1;
          end
        end else begin axi.M_AXI_WREADY = 1'b0; w_cnt = 0; end
        w_pv = axi.M_AXI_WVALID; w_pd = axi.M_AXI_WDATA; w_ps = axi.M_AXI_WSTRB;
        if (aw_done && w_done) begin b_pend = 1; b_cnt = 0; aw_done = 0; w_done = 0; end
        if (axi.M_AXI_ARVALID) begin
          if (ar_pv && axi.M_AXI_ARADDR != ar_pa) stab_err++;
          ar_hi++;
          axi.M_AXI_ARREADY = (ar_cnt >= c_ar); ar_cnt++;
          if (axi.M_AXI_ARREADY) begin
            ar_hs++; got_araddr = axi.M_AXI_ARADDR; r_pend = 1; r_cnt = 0;
          end
        end else begin axi.M_AXI_ARREADY = 1'b0; ar_cnt = 0; end
        ar_pv = axi.M_AXI_ARVALID; ar_pa = axi.M_AXI_ARADDR;
      end
    end
  end

  function automatic logic [6:0] ctl_bits();
    return {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
            axi.M_AXI_BREADY, axi.M_AXI_RREADY, rsp_valid, cmd_ready};
  endfunction

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic send(input vec_t v);
    int n, acc, hold_err;
    exp_t e;
    logic [31:0] s_data; logic [1:0] s_resp; logic s_wr; logic [LW-1:0] s_lat;
    c_aw = v.aw; c_w = v.w; c_b = v.b; c_ar = v.ar; c_r = v.r;
    c_resp = v.resp; c_rdata = v.rdata;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_before_accept", cmd_ready, 1);
    acc = cyc;
    e.data = v.exp_data; e.resp = v.resp; e.wr = v.wr; e.lat = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    chk("accept_to_rsp_cycles", cyc - acc, v.exp_cyc);
    s_data = rsp_data; s_resp = rsp_resp; s_wr = rsp_write; s_lat = rsp_latency;
    hold_err = 0;
    repeat (v.rdy) begin
      @(negedge clk);
      if (rsp_data != s_data || rsp_resp != s_resp || rsp_write != s_wr ||
          rsp_latency != s_lat || ctl_bits() != 7'b0000010) hold_err++;
    end
    chk("rsp_hold_stable", hold_err, 0);
    rsp_ready = 1'b1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_resp", rsp_resp, e.resp);
      chk("rsp_write", rsp_write, e.wr);
      chk("rsp_latency", rsp_latency, e.lat);
    end else chk("scoreboard_nonempty", 0, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_return", cmd_ready, 1);
    if (v.wr) begin
      chk("hs_counts_wr", {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0]}, 32'h01010100);
      chk("awaddr", got_awaddr, v.addr);
      chk("wdata", got_wdata, v.wdata);
      chk("wstrb", got_wstrb, v.strb);
      chk("awvalid_cycles", aw_hi, v.aw + 1);
      chk("wvalid_cycles", w_hi, v.w + 1);
    end else begin
      chk("hs_counts_rd", {ar_hs[7:0], r_hs[7:0], aw_hs[7:0], w_hs[7:0]}, 32'h01010000);
      chk("araddr", got_araddr, v.addr);
      chk("arvalid_cycles", ar_hi, v.ar + 1);
    end
  endtask

  initial begin
    int n, seen;
    vt[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'd0, 0, 32'h0, 8'd2, 3);
    vt[1] = mk(1, 32'h20, 32'hCAFEF00D, 4'h5, 0, 4, 1, 0, 0, 32'h0, 2'd1, 0, 32'h0, 8'd7, 8);
    vt[2] = mk(0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 2, 0, 32'h12345678, 2'd2, 0, 32'h12345678, 8'd4, 5);
    vt[3] = mk(1, 32'h30, 32'h01020304, 4'hC, 3, 0, 0, 0, 0, 32'h0, 2'd3, 5, 32'h0, 8'd5, 6);
    vt[4] = mk(0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 3, 32'hA5A55A5A, 2'd0, 2, 32'hA5A55A5A, 8'd5, 6);
    vt[5] = mk(1, 32'h50, 32'h0BADF00D, 4'hF, 0, 0, (1 << LW) + 5, 0, 0, 32'h0, 2'd1, 1, 32'h0, 8'hFF, 264);
    vt[6] = mk(0, 32'h60, 32'h0, 4'h0, 0, 0, 0, 1, 1, 32'h600DCAFE, 2'd0, 0, 32'h600DCAFE, 8'd4, 5);
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0; c_resp = 2'd0; c_rdata = '0;

    #12;
    chk("reset_ctl", ctl_bits(), 7'b0);
    chk("reset_rsp", {rsp_data, rsp_resp, rsp_write, rsp_latency}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_after_release", cmd_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) send(vt[i]);

    stray = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (axi.M_AXI_BREADY || axi.M_AXI_RREADY || rsp_valid) seen++;
    end
    stray = 1'b0;
    chk("stray_b_r_ignored", seen, 0);
    @(negedge clk);

    c_aw = 0; c_w = 0; c_b = 20; c_resp = 2'd3;
    cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h77777777; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!axi.M_AXI_BREADY && n < 10) begin @(negedge clk); n++; end
    chk("in_wr_resp", axi.M_AXI_BREADY, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctl", ctl_bits(), 7'b0);
    chk("midreset_rsp", {rsp_data, rsp_resp, rsp_write, rsp_latency}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_after_midreset", cmd_ready, 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || axi.M_AXI_BREADY) seen++;
    end
    chk("no_rsp_after_abandon", seen, 0);
    send(vt[6]);

    chk("scoreboard_empty", sb.size(), 0);
    chk("valid_payload_stable", stab_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
